// File: rtl/seq_detect_param.sv
// Serial pattern detector: matches a runtime-loaded PAT_W-bit sequence (MSB first)
// on en-qualified bits, with optional overlap and a saturating match counter.
module seq_detect_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic [1:0]       current_state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    HUNT = 2'b10
  } state_t;

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]    FULL    = FW'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_PRE = ~CNT_W'(1);

  state_t           state;
  logic [PAT_W-1:0] pat_r;
  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_next;
  logic             ovl_r;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_next;
  logic             match;

  assign current_state = state;

  always_comb begin
    hist_next = {hist[PAT_W-2:0], in};
    fill_next = (fill == FULL) ? fill : fill + 1'b1;
    match     = (fill_next == FULL) && (hist_next == pat_r);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      out       <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
      pat_r     <= '0;
      ovl_r     <= 1'b0;
      hist      <= '0;
      fill      <= '0;
    end else begin
      out <= 1'b0;
      if (cfg_load) begin
        pat_r <= pattern;
        ovl_r <= overlap;
        hist  <= '0;
        fill  <= '0;
        state <= FILL;
      end else begin
        case (state)
          IDLE: ;
          FILL, HUNT: begin
            if (en) begin
              if (match) begin
                out <= 1'b1;
                if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
                if (match_cnt == CNT_PRE) cnt_sat <= 1'b1;
              end
              // Non-overlapping mode restarts collection on the matching edge.
              if (match && !ovl_r) begin
                hist  <= '0;
                fill  <= '0;
                state <= FILL;
              end else begin
                hist  <= hist_next;
                fill  <= fill_next;
                state <= (fill_next == FULL) ? HUNT : FILL;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: two instances (CNT_W=8 and CNT_W=2) share
// stimulus; a queue-based reference model predicts every cycle's outputs.
`timescale 1ns/1ps
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic       cfg_load = 1'b0;
  logic       overlap = 1'b0;
  logic [3:0] pattern = '0;

  logic       out_a, sat_a, out_b, sat_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b, st_a, st_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .in(din), .cfg_load(cfg_load),
    .pattern(pattern), .overlap(overlap), .out(out_a), .match_cnt(cnt_a),
    .cnt_sat(sat_a), .current_state(st_a)
  );

  seq_detect_param #(.PAT_W(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .in(din), .cfg_load(cfg_load),
    .pattern(pattern), .overlap(overlap), .out(out_b), .match_cnt(cnt_b),
    .cnt_sat(sat_b), .current_state(st_b)
  );

  typedef struct {
    logic       o;
    logic [7:0] c8;
    logic       s8;
    logic [1:0] c2;
    logic       s2;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];

  // Reference model: accepted bits since the last clear, newest at the back.
  bit         m_cfg;
  logic [3:0] m_pat;
  logic       m_ovl;
  bit         m_hist[$];
  int         m_c8, m_c2;

  function automatic exp_t snapshot(logic o);
    exp_t e;
    e.o  = o;
    e.c8 = m_c8[7:0];
    e.s8 = (m_c8 == 255);
    e.c2 = m_c2[1:0];
    e.s2 = (m_c2 == 3);
    if (!m_cfg)                 e.st = 2'b00;
    else if (m_hist.size() == 4) e.st = 2'b10;
    else                        e.st = 2'b01;
    return e;
  endfunction

  function automatic logic model_step(logic c, logic [3:0] p, logic o, logic e, logic b);
    logic [3:0] win;
    logic       hit;
    hit = 1'b0;
    if (c) begin
      m_cfg = 1'b1;
      m_pat = p;
      m_ovl = o;
      m_hist.delete();
    end else if (m_cfg && e) begin
      m_hist.push_back(b);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      if (m_hist.size() == 4) begin
        win = '0;
        foreach (m_hist[i]) win = {win[2:0], m_hist[i]};
        if (win == m_pat) begin
          hit = 1'b1;
          if (m_c8 < 255) m_c8++;
          if (m_c2 < 3) m_c2++;
          if (!m_ovl) m_hist.delete();
        end
      end
    end
    return hit;
  endfunction

  task automatic step(logic c, logic [3:0] p, logic o, logic e, logic b);
    logic hit;
    @(negedge clk);
    cfg_load = c;
    pattern  = p;
    overlap  = o;
    en       = e;
    din      = b;
    hit = model_step(c, p, o, e, b);
    sb.push_back(snapshot(hit));
  endtask

  // Asserted on a falling edge, i.e. 5 ns before the next rising edge.
  task automatic do_reset();
    @(negedge clk);
    m_cfg = 1'b0;
    m_pat = '0;
    m_ovl = 1'b0;
    m_hist.delete();
    m_c8 = 0;
    m_c2 = 0;
    sb.push_back(snapshot(1'b0));
    cfg_load = 1'b0;
    en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_bits(logic [31:0] bits, int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 4'h0, 1'b0, 1'b1, bits[i]);
  endtask

  task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_a",   {7'b0, out_a}, {7'b0, e.o});
        chk("cnt_a",   cnt_a,         e.c8);
        chk("sat_a",   {7'b0, sat_a}, {7'b0, e.s8});
        chk("state_a", {6'b0, st_a},  {6'b0, e.st});
        chk("out_b",   {7'b0, out_b}, {7'b0, e.o});
        chk("cnt_b",   {6'b0, cnt_b}, {6'b0, e.c2});
        chk("sat_b",   {7'b0, sat_b}, {7'b0, e.s2});
        chk("state_b", {6'b0, st_b},  {6'b0, e.st});
      end
    end
  end

  initial begin : driver
    int r;
    do_reset();

    // 1011 overlapping, then non-overlapping
    step(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0);
    run_bits(32'b1011011, 7);
    do_reset();
    step(1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
    run_bits(32'b1011011, 7);

    // long stream with an early false-start region
    do_reset();
    step(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0);
    run_bits(32'b11110000101101100, 17);

    // en gap between bits 2 and 3
    do_reset();
    step(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0);
    run_bits(32'b10, 2);
    repeat (3) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    run_bits(32'b11, 2);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // reset mid-match, then bits without a new configuration
    do_reset();
    step(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0);
    run_bits(32'b101, 3);
    do_reset();
    run_bits(32'b11011011, 8);

    // cfg_load and en together: the bit is discarded
    step(1'b1, 4'b0110, 1'b1, 1'b1, 1'b0);
    step(1'b1, 4'b0110, 1'b1, 1'b1, 1'b1);
    run_bits(32'b0110110, 7);

    // all-zero pattern saturating the narrow counter, then reconfigure
    do_reset();
    step(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    run_bits(32'b0, 8);
    step(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 199));
      if (r < 2) do_reset();
      else step(r < 8, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    end

    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
